// File: rtl/ap_mult_tile_seq_pkg.sv
// Shared types and helpers for the sequential tiled approximate multiplier.
package ap_mult_seq_pkg;

  localparam int unsigned TILE_W = 4;
  // Widest pending vector the one-hot helper handles (DW up to 32).
  localparam int unsigned MAX_T  = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Number of 4x4 tiles needed to cover a DW x DW product.
  function automatic int unsigned tile_cnt(int unsigned dw);
    return (dw / TILE_W) * (dw / TILE_W);
  endfunction

  // Isolate the lowest set bit; selects the next tile to process.
  function automatic logic [MAX_T-1:0] lsb_onehot(logic [MAX_T-1:0] v);
    return v & (~v + MAX_T'(1));
  endfunction

endpackage

// File: rtl/ap_mult_tile_seq_if.sv
// Operand/result handshake bundle for ap_mult_tile_seq.
interface ap_mult_tile_seq_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] muld;
  logic [DW-1:0] mulr;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] res;
  logic          busy;

  modport master (
    output in_valid, muld, mulr, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, muld, mulr, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/ap_mult_tile_seq_tile.sv
// 4x4 unsigned approximate multiplier tile.
// Columns 0..3 are OR-compressed (no carries leave the low half);
// columns 4..6 are summed exactly. Result always fits 8 bits (max 191).
module ap_unsi_wall_4b_r4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  // pp[j][i] = a[i] & b[j], weight 2^(i+j)
  logic [3:0][3:0] pp;
  logic [3:0]      lo;
  logic [3:0]      hi;

  // Partial product array.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      pp[j] = a_i & {4{b_i[j]}};
    end
  end

  // Low columns approximated by OR, high columns summed exactly (hi is in units of 16).
  always_comb begin
    lo[0] = pp[0][0];
    lo[1] = pp[0][1] | pp[1][0];
    lo[2] = pp[0][2] | pp[1][1] | pp[2][0];
    lo[3] = pp[0][3] | pp[1][2] | pp[2][1] | pp[3][0];
    hi    = 4'(pp[1][3]) + 4'(pp[2][2]) + 4'(pp[3][1])
          + {2'b0, pp[2][3], 1'b0} + {2'b0, pp[3][2], 1'b0}
          + {1'b0, pp[3][3], 2'b0};
  end

  assign p_o = {hi, lo};

endmodule

// File: rtl/ap_mult_tile_seq.sv
// Sequential DWxDW approximate multiplier using a single 4x4 tile.
// One tile product is accumulated per CALC cycle, lowest pending tile first.
// Optional build macro: AP_SKIP_ZERO_EN -- skip tiles with a zero nibble operand.
module ap_mult_tile_seq
  import ap_mult_seq_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input logic               clk,
  input logic               rst,
  ap_mult_tile_seq_if.slave bus
);

  localparam int unsigned K  = DW / TILE_W;
  localparam int unsigned T  = tile_cnt(DW);
  localparam int unsigned RW = 2 * DW;

  state_e            state_q, state_d;
  logic [DW-1:0]     muld_q, muld_d;
  logic [DW-1:0]     mulr_q, mulr_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     res_q, res_d;
  logic [T-1:0]      pending_q, pending_d;
  logic [T-1:0]      mask;
  logic [MAX_T-1:0]  sel_full;
  logic [T-1:0]      sel;
  logic [TILE_W-1:0] nib_a, nib_b;
  logic [2*TILE_W-1:0] prod;
  logic [RW-1:0]     weight;
  logic [RW-1:0]     acc_sum;
  logic              last;

  // Pick the lowest pending tile.
  always_comb begin
    sel_full = lsb_onehot(MAX_T'(pending_q));
    sel      = sel_full[T-1:0];
  end

  if (T < MAX_T) begin : g_sel_hi
    logic unused_sel_hi;
    assign unused_sel_hi = ^sel_full[MAX_T-1:T];
  end

  // Nibble muxes: tile t uses muld nibble t%K and mulr nibble t/K.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int t = 0; t < int'(T); t++) begin
      if (sel[t]) begin
        nib_a = muld_q[TILE_W*(t%K) +: TILE_W];
        nib_b = mulr_q[TILE_W*(t/K) +: TILE_W];
      end
    end
  end

  ap_unsi_wall_4b_r4 u_tile (
    .a_i(nib_a),
    .b_i(nib_b),
    .p_o(prod)
  );

  // Shift the tile product to its column weight 4*(i+j).
  always_comb begin
    weight = '0;
    for (int t = 0; t < int'(T); t++) begin
      if (sel[t]) begin
        weight = RW'(prod) << (TILE_W * ((t % K) + (t / K)));
      end
    end
  end

  assign acc_sum = acc_q + weight;
  assign last    = ((pending_q & ~sel) == '0);

  // Tile mask computed from the incoming operands at accept time.
  always_comb begin
`ifdef AP_SKIP_ZERO_EN
    mask = '0;
    for (int t = 0; t < int'(T); t++) begin
      mask[t] = (bus.muld[TILE_W*(t%K) +: TILE_W] != '0) &&
                (bus.mulr[TILE_W*(t/K) +: TILE_W] != '0);
    end
`else
    mask = '1;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    muld_d    = muld_q;
    mulr_d    = mulr_q;
    acc_d     = acc_q;
    res_d     = res_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          muld_d    = bus.muld;
          mulr_d    = bus.mulr;
          acc_d     = '0;
          pending_d = mask;
          if (mask == '0) begin
            state_d = StDone;
            res_d   = '0;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d     = acc_sum;
        pending_d = pending_q & ~sel;
        if (last) begin
          state_d = StDone;
          res_d   = acc_sum;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      muld_q    <= '0;
      mulr_q    <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      muld_q    <= muld_d;
      mulr_q    <= mulr_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      pending_q <= pending_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.res       = res_q;

endmodule

// File: tb/tb_ap_mult_tile_seq.sv
// Directed bench for ap_mult_tile_seq (DW=8).
module tb_ap_mult_tile_seq;

  localparam int unsigned DW = 8;

`ifdef AP_SKIP_ZERO_EN
  localparam int LatSparse = 1;  // 0x10*0x01: one live tile
  localparam int LatZero   = 0;  // no live tiles: DONE on the accept edge
`else
  localparam int LatSparse = 4;
  localparam int LatZero   = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ap_mult_tile_seq_if #(.DW(DW)) bus ();

  ap_mult_tile_seq #(.DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit-level reference of the 4x4 tile, walked column by column.
  function automatic int ap4(input logic [3:0] a, input logic [3:0] b);
    int r = 0;
    for (int c = 0; c < 7; c++) begin
      int cnt = 0;
      for (int i = 0; i < 4; i++) begin
        int j = c - i;
        if (j >= 0 && j < 4 && a[i] && b[j]) cnt++;
      end
      if (c < 4) r += ((cnt != 0) ? 1 : 0) << c;
      else       r += cnt << c;
    end
    return r;
  endfunction

  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b);
    int s = 0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 2; i++) begin
        s += ap4(a[4*i +: 4], b[4*j +: 4]) << (4 * (i + j));
      end
    end
    return 16'(s);
  endfunction

  // Issue one op, measure latency in edges after the accept edge, hold DONE, drain.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input int exp_lat, input int hold,
                        input bit noise);
    int lat;
    check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.muld     = a;
    bus.mulr     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = noise;
    if (noise) begin
      bus.muld = ~a;
      bus.mulr = ~b;
    end
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, 32'(bus.res), 32'(exp_res));
    check_eq({tag, "_done_flags"}, 32'({bus.in_ready, bus.busy}), 32'b01);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold"}, 32'({bus.out_valid, bus.in_ready, bus.res}),
               32'({1'b1, 1'b0, exp_res}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_idle"}, 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
  endtask

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.muld      = 8'h55;
    bus.mulr      = 8'h55;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // rst held with in_valid high: must stay idle and cleared
    check_eq("rst_flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    check_eq("rst_res", 32'(bus.res), 32'h0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_no_accept", 32'({bus.in_ready, bus.busy}), 32'b10);

    // ap4(1,1)=1 at weight 16
    run_op("v10x01", 8'h10, 8'h01, 16'h0010, LatSparse, 0, 1'b0);
    // ap4(15,15)=191; 191*0x121 = 0xD79F; also backpressure for 5 cycles
    run_op("vFFxFF", 8'hFF, 8'hFF, 16'hD79F, 4, 5, 1'b0);
    run_op("v00xA5", 8'h00, 8'hA5, 16'h0000, LatZero, 0, 1'b0);
    // ap4(3,3)=7 (exact 9): 7*0x121 = 0x7E7; in_valid toggled during CALC
    run_op("v33x33", 8'h33, 8'h33, 16'h07E7, 4, 1, 1'b1);
    run_op("v9Cx7B", 8'h9C, 8'h7B, golden(8'h9C, 8'h7B), 4, 0, 1'b0);

    // Abort on the second CALC cycle
    check_eq("abort_ready", 32'(bus.in_ready), 32'd1);
    bus.muld     = 8'hFF;
    bus.mulr     = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    check_eq("abort_res", 32'(bus.res), 32'h0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);
    // 15 + (10+12)*16 + 8*256 = 0x96F
    run_op("v23x45", 8'h23, 8'h45, 16'h096F, 4, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
